// File: rtl/mem_wb_sequencer_pkg.sv
// rtl/mem_wb_sequencer_pkg.sv - shared register ids, FSM states and defaults
package mem_wb_sequencer_pkg;

  localparam int DW_DEF      = 16;
  localparam int AW_DEF      = 16;
  localparam int TIMEOUT_DEF = 15;

  localparam logic [5:0] REG_W    = 6'd34;
  localparam logic [5:0] REG_NULL = 6'd35;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } seq_state_t;

endpackage

// File: rtl/mem_wb_sequencer_timeout_ctr.sv
// rtl/mem_wb_sequencer_timeout_ctr.sv - request-wait counter with expire pulse
module mem_wb_sequencer_timeout_ctr
  import mem_wb_sequencer_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam logic [7:0] LP_LAST = 8'(TIMEOUT - 1);

  logic [7:0] r_count;

  // Holds at the last value instead of wrapping; the sequencer aborts there anyway.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_count <= 8'd0;
    end else if (i_enable && (r_count != LP_LAST)) begin
      r_count <= r_count + 8'd1;
    end
  end

  assign o_expire = i_enable && (r_count == LP_LAST);

endmodule

// File: rtl/mem_wb_sequencer.sv
// rtl/mem_wb_sequencer.sv - load/store handshake sequencer owning the writeback port
module mem_wb_sequencer
  import mem_wb_sequencer_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int AW      = AW_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_op_valid,
  output logic          o_op_ready,
  input  logic          i_MR,
  input  logic          i_MW,
  input  logic [AW-1:0] i_op_addr,
  input  logic [DW-1:0] i_W_IN,
  input  logic [DW-1:0] i_DATA_C,
  input  logic [5:0]    i_SEL_C,
  output logic          o_mem_req,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_W_MEM_OUT,
  input  logic          i_mem_ack,
  input  logic [DW-1:0] i_W_MEM_IN,
  output logic          o_wb_en,
  output logic [5:0]    o_SEL_REG,
  output logic [DW-1:0] o_DATA,
  output logic          o_stall,
  output logic          o_err
);

  seq_state_t    r_state, w_state_nxt;
  logic          r_mem_req, r_mem_we, r_wb_en, r_err;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_wdata, r_data;
  logic [5:0]    r_sel;

  logic          w_req_nxt, w_we_nxt, w_wb_nxt, w_err_nxt;
  logic [AW-1:0] w_addr_nxt;
  logic [DW-1:0] w_wdata_nxt, w_data_nxt;
  logic [5:0]    w_sel_nxt;
  logic          w_accept, w_in_req, w_expire, w_abort;

  assign o_op_ready = (r_state == ST_IDLE) && !i_rst;
  assign o_stall    = !o_op_ready;
  assign w_accept   = i_op_valid && o_op_ready;
  assign w_in_req   = (r_state == ST_REQ);
  assign w_abort    = w_expire && !i_mem_ack;

  mem_wb_sequencer_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout_ctr (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clear  (!w_in_req),
    .i_enable (w_in_req),
    .o_expire (w_expire)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept && (i_MR ^ i_MW)) w_state_nxt = ST_REQ;
      ST_REQ:  if (i_mem_ack || w_abort)      w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs; request fields hold unless reloaded.
  always_comb begin
    w_req_nxt   = r_mem_req;
    w_we_nxt    = r_mem_we;
    w_addr_nxt  = r_mem_addr;
    w_wdata_nxt = r_wdata;
    w_data_nxt  = r_data;
    w_sel_nxt   = REG_NULL;
    w_wb_nxt    = 1'b0;
    w_err_nxt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (i_MR && i_MW) begin
            w_err_nxt = 1'b1;
          end else if (i_MR || i_MW) begin
            w_req_nxt  = 1'b1;
            w_we_nxt   = i_MW;
            w_addr_nxt = i_op_addr;
            if (i_MW) w_wdata_nxt = i_W_IN;
          end else begin
            w_data_nxt = i_DATA_C;
            w_sel_nxt  = i_SEL_C;
            w_wb_nxt   = (i_SEL_C != REG_NULL);
          end
        end
      end
      ST_REQ: begin
        if (i_mem_ack) begin
          w_req_nxt = 1'b0;
          if (!r_mem_we) begin
            w_data_nxt = i_W_MEM_IN;
            w_sel_nxt  = REG_W;
            w_wb_nxt   = 1'b1;
          end
        end else if (w_abort) begin
          w_req_nxt = 1'b0;
          w_err_nxt = 1'b1;
        end
      end
      default: w_req_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mem_req  <= 1'b0;
      r_mem_we   <= 1'b0;
      r_mem_addr <= '0;
      r_wdata    <= '0;
      r_data     <= '0;
      r_sel      <= REG_NULL;
      r_wb_en    <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_mem_req  <= w_req_nxt;
      r_mem_we   <= w_we_nxt;
      r_mem_addr <= w_addr_nxt;
      r_wdata    <= w_wdata_nxt;
      r_data     <= w_data_nxt;
      r_sel      <= w_sel_nxt;
      r_wb_en    <= w_wb_nxt;
      r_err      <= w_err_nxt;
    end
  end

  assign o_mem_req   = r_mem_req;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_W_MEM_OUT = r_wdata;
  assign o_DATA      = r_data;
  assign o_SEL_REG   = r_sel;
  assign o_wb_en     = r_wb_en;
  assign o_err       = r_err;

endmodule

// File: tb/tb_mem_wb_sequencer.sv
// tb/tb_mem_wb_sequencer.sv - randomized bench against a transaction-level model
module tb_mem_wb_sequencer;

  localparam int DW      = 16;
  localparam int AW      = 16;
  localparam int TIMEOUT = 15;

  logic          clk = 1'b0;
  logic          i_rst, i_op_valid, i_MR, i_MW, i_mem_ack;
  logic [AW-1:0] i_op_addr;
  logic [DW-1:0] i_W_IN, i_DATA_C, i_W_MEM_IN;
  logic [5:0]    i_SEL_C;
  logic          o_op_ready, o_mem_req, o_mem_we, o_wb_en, o_stall, o_err;
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] o_W_MEM_OUT, o_DATA;
  logic [5:0]    o_SEL_REG;

  int n_checks = 0;
  int n_errors = 0;

  // model: one optional outstanding transaction plus last-writeback registers
  bit          m_busy;
  int          m_wait;
  logic        m_we;
  logic [15:0] m_addr, m_wout, m_data;
  logic [5:0]  m_sel;
  logic        m_wb, m_err;

  always #5 clk = ~clk;

  mem_wb_sequencer #(.DW(DW), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_op_valid  (i_op_valid),
    .o_op_ready  (o_op_ready),
    .i_MR        (i_MR),
    .i_MW        (i_MW),
    .i_op_addr   (i_op_addr),
    .i_W_IN      (i_W_IN),
    .i_DATA_C    (i_DATA_C),
    .i_SEL_C     (i_SEL_C),
    .o_mem_req   (o_mem_req),
    .o_mem_we    (o_mem_we),
    .o_mem_addr  (o_mem_addr),
    .o_W_MEM_OUT (o_W_MEM_OUT),
    .i_mem_ack   (i_mem_ack),
    .i_W_MEM_IN  (i_W_MEM_IN),
    .o_wb_en     (o_wb_en),
    .o_SEL_REG   (o_SEL_REG),
    .o_DATA      (o_DATA),
    .o_stall     (o_stall),
    .o_err       (o_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_wait = 0; m_we = 0;
    m_addr = 0; m_wout = 0; m_data = 0;
    m_sel = 6'd35; m_wb = 0; m_err = 0;
  endtask

  // One clock: drive inputs, compare current outputs, advance the model, clock.
  task automatic step(input logic rst, input logic valid, input logic mr, input logic mw,
                      input logic [15:0] addr, input logic [15:0] win, input logic [15:0] datac,
                      input logic [5:0] selc, input logic ack, input logic [15:0] rdata);
    @(negedge clk);
    i_rst = rst; i_op_valid = valid; i_MR = mr; i_MW = mw; i_op_addr = addr;
    i_W_IN = win; i_DATA_C = datac; i_SEL_C = selc; i_mem_ack = ack; i_W_MEM_IN = rdata;
    #1;
    check("op_ready", o_op_ready, !m_busy && !rst);
    check("stall", o_stall, m_busy || rst);
    check("mem_req", o_mem_req, m_busy);
    check("mem_we", o_mem_we, m_we);
    check("mem_addr", o_mem_addr, m_addr);
    check("W_MEM_OUT", o_W_MEM_OUT, m_wout);
    check("wb_en", o_wb_en, m_wb);
    check("SEL_REG", o_SEL_REG, m_sel);
    check("DATA", o_DATA, m_data);
    check("err", o_err, m_err);
    if (rst) begin
      model_reset();
    end else begin
      m_sel = 6'd35; m_wb = 0; m_err = 0;
      if (!m_busy) begin
        if (valid && mr && mw) begin
          m_err = 1;
        end else if (valid && (mr || mw)) begin
          m_busy = 1; m_wait = 0; m_we = mw; m_addr = addr;
          if (mw) m_wout = win;
        end else if (valid) begin
          m_data = datac; m_sel = selc; m_wb = (selc != 6'd35);
        end
      end else if (ack) begin
        m_busy = 0;
        if (!m_we) begin
          m_data = rdata; m_sel = 6'd34; m_wb = 1;
        end
      end else begin
        m_wait++;
        if (m_wait == TIMEOUT) begin
          m_busy = 0; m_err = 1;
        end
      end
    end
    @(posedge clk);
  endtask

  task automatic idle(input logic ack, input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 6'd35, ack, 16'h5A5A);
  endtask

  initial begin
    i_rst = 1; i_op_valid = 0; i_MR = 0; i_MW = 0; i_op_addr = 0;
    i_W_IN = 0; i_DATA_C = 0; i_SEL_C = 6'd35; i_mem_ack = 0; i_W_MEM_IN = 0;
    repeat (2) @(posedge clk);
    model_reset();
    step(1, 0, 0, 0, 16'h0, 16'h0, 16'h0, 6'd35, 0, 16'h0);

    // back-to-back ALU writebacks
    step(0, 1, 0, 0, 16'h0, 16'h0, 16'h1234, 6'd5, 0, 16'h0);
    step(0, 1, 0, 0, 16'h0, 16'h0, 16'hBEEF, 6'd6, 0, 16'h0);
    idle(0, 2);

    // load, ack three cycles after request
    step(0, 1, 1, 0, 16'h0040, 16'h0, 16'h0, 6'd1, 0, 16'h0);
    idle(0, 3);
    step(0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 6'd35, 1, 16'hA5A5);
    idle(0, 2);

    // store, ack one cycle after request
    step(0, 1, 0, 1, 16'h0010, 16'h00FF, 16'h0, 6'd2, 0, 16'h0);
    idle(0, 1);
    idle(1, 1);
    idle(0, 2);

    // load that never completes
    step(0, 1, 1, 0, 16'h0080, 16'h0, 16'h0, 6'd3, 0, 16'h0);
    idle(0, TIMEOUT + 4);

    // illegal read+write, spurious ack in idle
    step(0, 1, 1, 1, 16'h0020, 16'h1111, 16'h0, 6'd4, 1, 16'h0);
    idle(1, 2);

    // reset in the middle of a request, then a late ack
    step(0, 1, 1, 0, 16'h0030, 16'h0, 16'h0, 6'd7, 0, 16'h0);
    idle(0, 1);
    step(1, 1, 0, 0, 16'h0, 16'h0, 16'h7777, 6'd8, 0, 16'h0);
    idle(1, 2);

    for (int i = 0; i < 600; i++) begin
      logic r, v, a;
      r = ($urandom_range(0, 60) == 0);
      v = ($urandom_range(0, 9) < 7);
      a = (i < 300) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 24) == 0);
      step(r, v, 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
           6'($urandom_range(30, 35)), a, 16'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
